// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: owns the PC, loads the instruction register from program memory
// and issues it over a valid/ready handshake. Define FETCH_SEQ_LOOP_EN to wrap at LAST_ADDR.
module fetch_sequencer #(
  parameter int unsigned ADDR_W    = 5,
  parameter int unsigned INS_W     = 13,
  parameter int unsigned LAST_ADDR = 31,
  parameter int unsigned CNT_W     = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              halt_req,
  output logic [ADDR_W-1:0] pm_addr,
  input  logic [INS_W-1:0]  pm_ins,
  output logic [INS_W-1:0]  ir,
  output logic              ir_valid,
  input  logic              ir_ready,
  input  logic              jmp_en,
  input  logic [ADDR_W-1:0] jmp_addr,
  output logic [ADDR_W-1:0] pc,
  output logic              halted,
  output logic [CNT_W-1:0]  issued_cnt
);

  typedef enum logic [1:0] {StIdle, StFetch, StIssue, StHalted} state_e;

  state_e             state_q, state_d;
  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic [INS_W-1:0]   ir_q, ir_d;
  logic               ir_valid_q, ir_valid_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic               handshake;
  logic               at_last;
  logic [ADDR_W-1:0]  pc_seq;
  logic [ADDR_W-1:0]  pc_next;
  logic [CNT_W-1:0]   cnt_inc;

  assign handshake = ir_valid_q & ir_ready;
  assign at_last   = (pc_q == ADDR_W'(LAST_ADDR));

  // Sequential successor of the PC; the end-of-program case never wraps unless looping.
  always_comb begin
    pc_seq = pc_q + ADDR_W'(1);
    if (at_last) begin
`ifdef FETCH_SEQ_LOOP_EN
      pc_seq = '0;
`else
      pc_seq = pc_q;
`endif
    end
  end

  assign pc_next = jmp_en ? jmp_addr : pc_seq;
  assign cnt_inc = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + CNT_W'(1);

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    ir_d       = ir_q;
    ir_valid_d = ir_valid_q;
    cnt_d      = cnt_q;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StFetch;
          pc_d    = '0;
          cnt_d   = '0;
        end
      end

      StFetch: begin
        if (halt_req) begin
          state_d = StHalted;
        end else begin
          ir_d       = pm_ins;
          ir_valid_d = 1'b1;
          state_d    = StIssue;
        end
      end

      StIssue: begin
        // halt_req is level-sensitive: it only matters on the handshake cycle itself.
        if (handshake) begin
          ir_valid_d = 1'b0;
          cnt_d      = cnt_inc;
          pc_d       = pc_next;
          if (halt_req) begin
            state_d = StHalted;
          end else if (at_last && !jmp_en) begin
`ifdef FETCH_SEQ_LOOP_EN
            state_d = StFetch;
`else
            state_d = StHalted;
`endif
          end else begin
            state_d = StFetch;
          end
        end
      end

      StHalted: begin
        ir_valid_d = 1'b0;
        if (start) begin
          state_d = StFetch;
          pc_d    = '0;
          cnt_d   = '0;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      pc_q       <= '0;
      ir_q       <= '0;
      ir_valid_q <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      ir_q       <= ir_d;
      ir_valid_q <= ir_valid_d;
      cnt_q      <= cnt_d;
    end
  end

  assign pm_addr    = pc_q;
  assign pc         = pc_q;
  assign ir         = ir_q;
  assign ir_valid   = ir_valid_q;
  assign halted     = (state_q == StHalted);
  assign issued_cnt = cnt_q;

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Sequences instruction fetch from the 32-entry, 13-bit combinational program memory.
- Owns the program counter and drives the memory address.
- Registers each fetched word into an instruction register and hands it to the execute datapath over a valid/ready handshake.
- Supports start, halt and jumps, and counts issued instructions.

Parameters:
- ADDR_W, 5, program counter / memory address width
- INS_W, 13, instruction width ({opcode[12:8], operand[7:0]})
- LAST_ADDR, 31, highest program address; end-of-program boundary
- CNT_W, 8, width of issued-instruction counter

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- start  input  1  begin/restart execution at address 0 (sampled in IDLE or HALTED only)
- halt_req  input  1  stop after current instruction handshake (or immediately if none pending)
- pm_addr  output  ADDR_W  program memory address, equals pc combinationally
- pm_ins  input  INS_W  program memory read data (combinational from pm_addr)
- ir  output  INS_W  registered instruction to datapath
- ir_valid  output  1  ir holds an unconsumed instruction
- ir_ready  input  1  datapath accepts ir this cycle
- jmp_en  input  1  on handshake cycle, next pc = jmp_addr
- jmp_addr  input  ADDR_W  jump target
- pc  output  ADDR_W  current program counter
- halted  output  1  high in HALTED state
- issued_cnt  output  CNT_W  instructions accepted since start, saturating

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE, pc=0, ir=0, ir_valid=0, halted=0, issued_cnt=0.
  - Reset mid-operation discards any pending ir with no handshake.
- States: IDLE, FETCH, ISSUE, HALTED.
- IDLE:
  - start=1 -> FETCH, pc=0, issued_cnt=0.
  - halt_req is ignored.
- FETCH (one cycle):
  - At the clock edge, ir<=pm_ins, ir_valid<=1, -> ISSUE.
  - halt_req=1 in FETCH -> HALTED instead; no load, ir_valid stays 0.
- ISSUE:
  - ir and ir_valid are held stable until ir_valid&ir_ready.
  - On the handshake edge:
    - ir_valid<=0.
    - issued_cnt+=1, saturating at 2^CNT_W-1.
    - Next pc = jmp_en ? jmp_addr : pc+1.
  - Next state after the handshake:
    - halt_req=1 that cycle -> HALTED; pc still updates.
    - else pc==LAST_ADDR and jmp_en=0 -> HALTED; pc is left at LAST_ADDR, not wrapped.
    - else -> FETCH.
  - halt_req=1 without ready: remains in ISSUE; the instruction must still be consumed, and the halt is applied on that handshake only if halt_req is still high. halt_req is level-sensitive and is not latched.
  - jmp_en/jmp_addr are ignored outside handshake cycles.
- HALTED:
  - halted=1, ir_valid=0.
  - start=1 -> FETCH with pc=0, issued_cnt=0, halted<=0.
- start is ignored in FETCH and ISSUE.
- Latency: start at edge k -> ir_valid=1 after edge k+1. Peak throughput is 1 instruction per 2 cycles (FETCH+ISSUE).
- pm_addr=pc at all times. pm_ins is assumed valid in the same cycle.

Optional Feature:
- Macro FETCH_SEQ_LOOP_EN.
- When defined: handshake at pc==LAST_ADDR with jmp_en=0 wraps pc to 0 and continues to FETCH. Only halt_req stops execution.
- When undefined: end-of-program halts as described in Behaviour.

Test Plan:
- Reset then start pulse, ir_ready tied 1, memory words 0..3 distinct -> ir sequence = Mem[0],Mem[1],Mem[2],Mem[3], ir_valid pulses every 2nd cycle, issued_cnt=4 after 4 handshakes.
- ir_ready held 0 for 5 cycles in ISSUE at pc=2 -> ir and ir_valid stable at Mem[2], pc stays 2; ready 1 -> pc=3.
- Handshake at pc=4 with jmp_en=1, jmp_addr=17 -> next pm_addr=17, next ir=Mem[17]; jmp_en=1 outside handshake has no effect.
- Run to pc=31, ready=1 -> halted=1 after handshake, pc=31, issued_cnt=32. With FETCH_SEQ_LOOP_EN: pc=0, ir=Mem[0], issued_cnt saturates at 255 after 255 issues.
- halt_req with handshake at pc=6 -> halted=1, pc=7, ir_valid=0. Then start -> pc=0, issued_cnt=0, ir=Mem[0].
- rst_n asserted low mid-ISSUE (ir_valid=1, pc=9) -> ir_valid=0, pc=0, state IDLE immediately, no clock needed.
